multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM that drives the 4-bit ALU operation code and all datapath strobes.
//  It sequences fetch/decode/execute/memory/writeback, and consumes the ALU zero flag
//  (asserted only for op 1111 when A<B).
//  It sits between the instruction register and the datapath. It is the producer of ALUcontrol.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/alu_func_decoder.sv | 32 +++
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: ALU op codes, opcode/funct fields,
// datapath mux selects and the FSM state type.
package cpu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_SUB  = 4'b1001;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_SLL1 = 4'b1011;
  localparam logic [3:0] ALU_SRL1 = 4'b1010;
  localparam logic [3:0] ALU_SRA1 = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BLT   = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLL1 = 6'b000000;
  localparam logic [5:0] F_SRL1 = 6'b000010;
  localparam logic [5:0] F_SRA1 = 6'b000011;
  localparam logic [5:0] F_SLT  = 6'b101010;

  localparam logic [1:0] SRC_B_RT     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR   = 2'd1;
  localparam logic [1:0] SRC_B_IMM    = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SH = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'd0;
  localparam logic [1:0] WB_SEL_MDR    = 2'd1;
  localparam logic [1:0] WB_SEL_SLT    = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

endpackage

// File: rtl/alu_func_decoder.sv
// Combinational R-type funct decoder: ALU op code, SLT marker and a validity flag.
module alu_func_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       is_slt,
  output logic       valid
);

  always_comb begin
    alu_control = 4'b0000;
    is_slt      = 1'b0;
    valid       = 1'b1;
    case (funct)
      F_ADD:   alu_control = ALU_ADD;
      F_ADDU:  alu_control = ALU_ADDU;
      F_SUB:   alu_control = ALU_SUB;
      F_AND:   alu_control = ALU_AND;
      F_OR:    alu_control = ALU_OR;
      F_SLL1:  alu_control = ALU_SLL1;
      F_SRL1:  alu_control = ALU_SRL1;
      F_SRA1:  alu_control = ALU_SRA1;
      F_SLT: begin
        alu_control = ALU_SLT;
        is_slt      = 1'b1;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback and drives
// the ALU op code and every datapath strobe as a Moore decode of the state register.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [3:0]       alu_control,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        r_alu_op;
  logic              r_is_slt;
  logic              r_valid;

  alu_func_decoder u_func_dec (
    .funct       (funct),
    .alu_control (r_alu_op),
    .is_slt      (r_is_slt),
    .valid       (r_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      case (state)
        // All three memory states share the timeout; the counter only runs in them
        S_FETCH, S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            wait_cnt <= '0;
            case (state)
              S_FETCH:  state <= S_DECODE;
              S_MEM_RD: state <= S_WB_MEM;
              default: begin
                state       <= S_FETCH;
                instr_count <= instr_count + CNT_W'(1);
              end
            endcase
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= S_TRAP;
            bus_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          case (opcode)
            OP_RTYPE:             state <= S_EXEC_R;
            OP_LW, OP_SW, OP_ADDI: state <= S_EXEC_I;
            OP_BLT:               state <= S_BRANCH;
            OP_J:                 state <= S_JUMP;
            default: begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC_R: begin
          wait_cnt <= '0;
          if (r_valid) begin
            state <= S_WB_R;
          end else begin
            state   <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC_I: begin
          wait_cnt <= '0;
          case (opcode)
            OP_ADDI: state <= S_WB_I;
            OP_LW:   state <= S_MEM_RD;
            OP_SW:   state <= S_MEM_WR;
            default: begin
              state   <= S_TRAP;
              illegal <= 1'b1;
            end
          endcase
        end
        S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: begin
          wait_cnt    <= '0;
          state       <= S_FETCH;
          instr_count <= instr_count + CNT_W'(1);
        end
        default: begin
          wait_cnt <= '0;
          state    <= S_TRAP;
        end
      endcase
    end
  end

  // Reset overrides the decode so nothing leaves the controller in the cycle rst rises
  always_comb begin
    alu_control = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = SRC_B_RT;
    pc_write    = 1'b0;
    pc_src      = PC_SRC_ALU;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    wb_sel      = WB_SEL_ALUOUT;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = SRC_B_FOUR;
          alu_control = ALU_ADD;
          ir_write    = mem_ready;
          pc_write    = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = SRC_B_IMM_SH;
          alu_control = ALU_ADD;
        end
        S_EXEC_R: begin
          alu_src_a   = 1'b1;
          alu_control = r_alu_op;
        end
        S_WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          wb_sel    = r_is_slt ? WB_SEL_SLT : WB_SEL_ALUOUT;
        end
        S_EXEC_I: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRC_B_IMM;
          alu_control = ALU_ADD;
        end
        S_WB_I:   reg_write = 1'b1;
        S_MEM_RD: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
        end
        S_WB_MEM: begin
          reg_write = 1'b1;
          wb_sel    = WB_SEL_MDR;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          i_or_d  = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SLT;
          pc_src      = PC_SRC_ALUOUT;
          pc_write    = zero;
        end
        S_JUMP: begin
          pc_src   = PC_SRC_JUMP;
          pc_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl: one row per clock cycle,
// followed by hand-written trap, reset-from-trap and bus-timeout sequences.
module tb_multicycle_ctrl;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BLT  = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRA1 = 6'b000011;
  localparam logic [5:0] FN_BAD  = 6'b111111;

  localparam logic [19:0] FLAG_ILL = 20'h00002;
  localparam logic [19:0] FLAG_BE  = 20'h00001;
  localparam logic [19:0] ALL      = 20'hFFFFF;
  localparam logic [19:0] NO_FLAGS = 20'hFFFFC;

  typedef struct {
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic [19:0] exp_word;
    logic [31:0] exp_count;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  alu_control;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        mem_req;
  logic        mem_we;
  logic        i_or_d;
  logic        ir_write;
  logic        reg_write;
  logic        reg_dst;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic        bus_error;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  logic [19:0] e_fetch_wait, e_fetch_go, e_decode, e_wb_r, e_wb_slt, e_exec_i;
  logic [19:0] e_wb_i, e_mem_rd, e_wb_mem, e_mem_wr, e_br_t, e_br_n, e_jump;

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_control (alu_control),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .i_or_d      (i_or_d),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .bus_error   (bus_error),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  // Expected-output word: alu, src_a, src_b, pc_write, pc_src, mem_req, mem_we, i_or_d,
  // ir_write, reg_write, reg_dst, wb_sel, then the illegal/bus_error flags (left at 0 here)
  function automatic logic [19:0] w(input logic [3:0] alu, input logic a, input logic [1:0] b,
                                    input logic pcw, input logic [1:0] pcs, input logic mreq,
                                    input logic mwe, input logic iod, input logic irw,
                                    input logic rw, input logic rd, input logic [1:0] wb);
    return {alu, a, b, pcw, pcs, mreq, mwe, iod, irw, rw, rd, wb, 2'b00};
  endfunction

  function automatic logic [19:0] actualWord();
    return {alu_control, alu_src_a, alu_src_b, pc_write, pc_src, mem_req, mem_we, i_or_d,
            ir_write, reg_write, reg_dst, wb_sel, illegal, bus_error};
  endfunction

  task automatic addVector(input logic r, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input logic rdy, input logic [19:0] ew,
                           input logic [31:0] ec);
    vec_t v;
    v.rst = r; v.opcode = op; v.funct = fn; v.zero = z; v.mem_ready = rdy;
    v.exp_word = ew; v.exp_count = ec;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [5:0] op, input logic [5:0] fn,
                               input logic z, input logic rdy);
    @(negedge clk);
    rst = r; opcode = op; funct = fn; zero = z; mem_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [19:0] exp_word,
                             input logic [19:0] mask, input logic [31:0] exp_count);
    logic [19:0] got;
    got = actualWord();
    checks++;
    if ((got & mask) !== (exp_word & mask)) begin
      errors++;
      $display("[TB] FAIL %s outputs: got %b expected %b", name, got & mask, exp_word & mask);
    end
    checks++;
    if (instr_count !== exp_count) begin
      errors++;
      $display("[TB] FAIL %s instr_count: got %0d expected %0d", name, instr_count, exp_count);
    end
  endtask

  initial begin
    e_fetch_wait = w(4'b1000, 0, 2'd1, 0, 2'd0, 1, 0, 0, 0, 0, 0, 2'd0);
    e_fetch_go   = w(4'b1000, 0, 2'd1, 1, 2'd0, 1, 0, 0, 1, 0, 0, 2'd0);
    e_decode     = w(4'b1000, 0, 2'd3, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    e_wb_r       = w(4'b0000, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 2'd0);
    e_wb_slt     = w(4'b0000, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 1, 2'd2);
    e_exec_i     = w(4'b1000, 1, 2'd2, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0);
    e_wb_i       = w(4'b0000, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 2'd0);
    e_mem_rd     = w(4'b0000, 0, 2'd0, 0, 2'd0, 1, 0, 1, 0, 0, 0, 2'd0);
    e_wb_mem     = w(4'b0000, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 1, 0, 2'd1);
    e_mem_wr     = w(4'b0000, 0, 2'd0, 0, 2'd0, 1, 1, 1, 0, 0, 0, 2'd0);
    e_br_t       = w(4'b1111, 1, 2'd0, 1, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0);
    e_br_n       = w(4'b1111, 1, 2'd0, 0, 2'd1, 0, 0, 0, 0, 0, 0, 2'd0);
    e_jump       = w(4'b0000, 0, 2'd0, 1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd0);

    // reset row, then add / sub / slt / sra1 R-types (4 cycles each)
    addVector(1, OP_R, FN_ADD, 0, 0, 20'h0, 0);
    addVector(0, OP_R, FN_ADD, 0, 1, e_fetch_go, 0);
    addVector(0, OP_R, FN_ADD, 0, 1, e_decode, 0);
    addVector(0, OP_R, FN_ADD, 0, 1, w(4'b1000, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 0);
    addVector(0, OP_R, FN_ADD, 0, 1, e_wb_r, 0);
    addVector(0, OP_R, FN_SUB, 0, 1, e_fetch_go, 1);
    addVector(0, OP_R, FN_SUB, 0, 0, e_decode, 1);
    addVector(0, OP_R, FN_SUB, 0, 0, w(4'b1001, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 1);
    addVector(0, OP_R, FN_SUB, 0, 0, e_wb_r, 1);
    addVector(0, OP_R, FN_SLT, 0, 1, e_fetch_go, 2);
    addVector(0, OP_R, FN_SLT, 0, 0, e_decode, 2);
    addVector(0, OP_R, FN_SLT, 0, 0, w(4'b1111, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 2);
    addVector(0, OP_R, FN_SLT, 0, 0, e_wb_slt, 2);
    addVector(0, OP_R, FN_SRA1, 0, 1, e_fetch_go, 3);
    addVector(0, OP_R, FN_SRA1, 0, 0, e_decode, 3);
    addVector(0, OP_R, FN_SRA1, 0, 0, w(4'b0010, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 3);
    addVector(0, OP_R, FN_SRA1, 0, 0, e_wb_r, 3);
    // addi, then lw with three idle cycles in MEM_RD
    addVector(0, OP_ADDI, 6'd0, 0, 1, e_fetch_go, 4);
    addVector(0, OP_ADDI, 6'd0, 0, 0, e_decode, 4);
    addVector(0, OP_ADDI, 6'd0, 0, 0, e_exec_i, 4);
    addVector(0, OP_ADDI, 6'd0, 0, 0, e_wb_i, 4);
    addVector(0, OP_LW, 6'd0, 0, 1, e_fetch_go, 5);
    addVector(0, OP_LW, 6'd0, 0, 0, e_decode, 5);
    addVector(0, OP_LW, 6'd0, 0, 0, e_exec_i, 5);
    addVector(0, OP_LW, 6'd0, 0, 0, e_mem_rd, 5);
    addVector(0, OP_LW, 6'd0, 0, 0, e_mem_rd, 5);
    addVector(0, OP_LW, 6'd0, 0, 0, e_mem_rd, 5);
    addVector(0, OP_LW, 6'd0, 0, 1, e_mem_rd, 5);
    addVector(0, OP_LW, 6'd0, 0, 1, e_wb_mem, 5);
    // sw with one idle fetch cycle
    addVector(0, OP_SW, 6'd0, 0, 0, e_fetch_wait, 6);
    addVector(0, OP_SW, 6'd0, 0, 1, e_fetch_go, 6);
    addVector(0, OP_SW, 6'd0, 0, 0, e_decode, 6);
    addVector(0, OP_SW, 6'd0, 0, 0, e_exec_i, 6);
    addVector(0, OP_SW, 6'd0, 0, 1, e_mem_wr, 6);
    // blt taken, blt not taken, j
    addVector(0, OP_BLT, 6'd0, 1, 1, e_fetch_go, 7);
    addVector(0, OP_BLT, 6'd0, 1, 0, e_decode, 7);
    addVector(0, OP_BLT, 6'd0, 1, 0, e_br_t, 7);
    addVector(0, OP_BLT, 6'd0, 0, 1, e_fetch_go, 8);
    addVector(0, OP_BLT, 6'd0, 0, 0, e_decode, 8);
    addVector(0, OP_BLT, 6'd0, 0, 0, e_br_n, 8);
    addVector(0, OP_J, 6'd0, 0, 1, e_fetch_go, 9);
    addVector(0, OP_J, 6'd0, 0, 0, e_decode, 9);
    addVector(0, OP_J, 6'd0, 0, 0, e_jump, 9);
    // add aborted by reset in EXEC_R: no writeback, FETCH follows
    addVector(0, OP_R, FN_ADD, 0, 1, e_fetch_go, 10);
    addVector(0, OP_R, FN_ADD, 0, 0, e_decode, 10);
    addVector(1, OP_R, FN_ADD, 0, 0, 20'h0, 10);
    addVector(0, OP_R, FN_ADD, 0, 0, e_fetch_wait, 0);
    // unknown funct traps; mem_ready afterwards is ignored
    addVector(0, OP_R, FN_BAD, 0, 1, e_fetch_go, 0);
    addVector(0, OP_R, FN_BAD, 0, 0, e_decode, 0);
    addVector(0, OP_R, FN_BAD, 0, 0, w(4'b0000, 1, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0), 0);
    addVector(0, OP_R, FN_BAD, 0, 0, FLAG_ILL, 0);
    addVector(0, OP_R, FN_BAD, 1, 1, FLAG_ILL, 0);

    rst = 1'b1; opcode = OP_R; funct = FN_ADD; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].opcode, vecs[i].funct, vecs[i].zero, vecs[i].mem_ready);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_word, ALL, vecs[i].exp_count);
    end

    // reset out of TRAP clears illegal
    applyStimulus(1, OP_R, FN_ADD, 0, 1);
    checkOutput("trap_rst", 20'h0, NO_FLAGS, 0);
    applyStimulus(0, OP_R, FN_ADD, 0, 0);
    checkOutput("trap_rst_fetch", e_fetch_wait, ALL, 0);

    // undecodable opcode traps from DECODE; strobes stay off under mem_ready pulses
    applyStimulus(0, OP_BAD, FN_ADD, 0, 1);
    checkOutput("bad_op_fetch", e_fetch_go, ALL, 0);
    applyStimulus(0, OP_BAD, FN_ADD, 0, 0);
    checkOutput("bad_op_decode", e_decode, ALL, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, OP_BAD, FN_ADD, 1, i[0]);
      checkOutput($sformatf("bad_op_trap%0d", i), FLAG_ILL, ALL, 0);
    end
    applyStimulus(1, OP_R, FN_ADD, 0, 0);
    checkOutput("bad_op_rst", 20'h0, NO_FLAGS, 0);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("bad_op_clear", e_fetch_go, ALL, 0);

    // fetch timeout: 15 waiting cycles, then TRAP with bus_error
    applyStimulus(1, OP_R, FN_ADD, 0, 0);
    checkOutput("to_rst", 20'h0, NO_FLAGS, 0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, OP_R, FN_ADD, 0, 0);
      checkOutput($sformatf("to_wait%0d", i), e_fetch_wait, ALL, 0);
    end
    applyStimulus(0, OP_R, FN_ADD, 0, 0);
    checkOutput("to_trap", FLAG_BE, ALL, 0);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("to_trap_ready", FLAG_BE, ALL, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
